// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared CPU constants and the port-select type used by the writeback arbiter.
package regfile_wr_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant with a force-B override for same-register collisions.
module rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       force_b_i,
    output logic [1:0] gnt_o
);

    port_sel_e  last_q, last_d;
    logic [1:0] gnt_d;

    always_comb begin
        gnt_d  = 2'b00;
        last_d = last_q;
        if (rst_ni) begin
            if (req_a_i && req_b_i) begin
                // A tie goes to whoever did not win last, unless B is forced
                if (force_b_i || last_q == PORT_A) gnt_d[PORT_B] = 1'b1;
                else                               gnt_d[PORT_A] = 1'b1;
            end else begin
                gnt_d[PORT_A] = req_a_i;
                gnt_d[PORT_B] = req_b_i;
            end
        end
        if (gnt_d[PORT_A])      last_d = PORT_A;
        else if (gnt_d[PORT_B]) last_d = PORT_B;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) last_q <= PORT_B;
        else         last_q <= last_d;
    end

    assign gnt_o = gnt_d;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the main writeback (A) and an
// auxiliary long-latency unit (B); registers the winning write.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWre,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  cont_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [1:0]        gnt;
    logic              same_reg;
    logic              xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              regwre_q, regwre_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // B goes first on a same-register clash so A's value lands last
    assign same_reg = (a_reg == b_reg) && (a_reg != ZERO_IDX);

    rr_arb2 u_arb (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .req_a_i  (a_valid),
        .req_b_i  (b_valid),
        .force_b_i(same_reg),
        .gnt_o    (gnt)
    );

    assign a_ready  = gnt[PORT_A];
    assign b_ready  = gnt[PORT_B];
    assign xfer     = |gnt;
    assign sel_reg  = gnt[PORT_B] ? b_reg  : a_reg;
    assign sel_data = gnt[PORT_B] ? b_data : a_data;

    always_comb begin
        regwre_d = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (xfer && sel_reg != ZERO_IDX) begin
            regwre_d = 1'b1;
            wreg_d   = sel_reg;
            wdata_d  = sel_data;
        end
        cnt_d = cnt_q;
        if (a_valid && b_valid && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            regwre_q <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            regwre_q <= regwre_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign RegWre    = regwre_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;
    assign cont_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a negedge-sampling register-file model.
module tb_regfile_wr_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_reg = '0, b_reg = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [7:0]  cont_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf [32];

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData), .cont_cnt(cont_cnt)
    );

    always #5 CLK = ~CLK;

    // register file write port samples on the negedge
    always @(negedge CLK) if (RegWre) rf[WriteReg] <= WriteData;

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h22;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        total++; if ({a_ready, b_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready}); end
        total++; if (RegWre !== 1'b0) begin bad++; $display("FAIL reset_regwre got=%b exp=0", RegWre); end
        total++; if (WriteReg !== 5'd0) begin bad++; $display("FAIL reset_writereg got=%0d exp=0", WriteReg); end
        total++; if (WriteData !== 32'h0) begin bad++; $display("FAIL reset_writedata got=%h exp=0", WriteData); end
        total++; if (cont_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cont_cnt); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h12345678;
        @(negedge CLK);
        total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {a_ready, b_ready}); end
        @(posedge CLK); #1 a_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd3, 32'h12345678})
            begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/12345678", RegWre, WriteReg, WriteData); end
        @(posedge CLK); @(negedge CLK);
        total++; if (RegWre !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", RegWre); end
        @(posedge CLK); #1;
        total++; if (rf[3] !== 32'h12345678) begin bad++; $display("FAIL single_rf got=%h exp=12345678", rf[3]); end
    endtask

    task automatic test_tie();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd4; a_data = 32'hA;
        b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hB;
        @(negedge CLK);
        total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL tie_first got=%b exp=10", {a_ready, b_ready}); end
        @(posedge CLK); #1 a_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd4, 32'hA})
            begin bad++; $display("FAIL tie_wr_a got=%b/%0d/%h exp=1/4/a", RegWre, WriteReg, WriteData); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL tie_second got=%b exp=1", b_ready); end
        @(posedge CLK); #1 b_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd5, 32'hB})
            begin bad++; $display("FAIL tie_wr_b got=%b/%0d/%h exp=1/5/b", RegWre, WriteReg, WriteData); end
        total++; if (cont_cnt !== 8'd1) begin bad++; $display("FAIL tie_cnt got=%0d exp=1", cont_cnt); end
        @(posedge CLK); @(negedge CLK);
        total++; if (RegWre !== 1'b0) begin bad++; $display("FAIL tie_idle got=%b exp=0", RegWre); end
    endtask

    task automatic test_collision();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h1;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h2;
        @(negedge CLK);
        total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL coll_first got=%b exp=01", {a_ready, b_ready}); end
        @(posedge CLK); #1 b_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd7, 32'h2})
            begin bad++; $display("FAIL coll_wr_b got=%b/%0d/%h exp=1/7/2", RegWre, WriteReg, WriteData); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL coll_second got=%b exp=1", a_ready); end
        @(posedge CLK); #1 a_valid = 1'b0;
        @(negedge CLK);
        total++; if (WriteData !== 32'h1) begin bad++; $display("FAIL coll_wr_a got=%h exp=1", WriteData); end
        @(posedge CLK); #1;
        total++; if (rf[7] !== 32'h1) begin bad++; $display("FAIL coll_rf got=%h exp=1", rf[7]); end
    endtask

    task automatic test_zero();
        do_reset();
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
        @(negedge CLK);
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", b_ready); end
        @(posedge CLK); #1 b_valid = 1'b0;
        @(negedge CLK);
        total++; if (RegWre !== 1'b0) begin bad++; $display("FAIL zero_regwre got=%b exp=0", RegWre); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd8; a_data = 32'h80;
        @(negedge CLK);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_a1 got=%b exp=1", a_ready); end
        @(posedge CLK); #1;
        a_reg = 5'd9; a_data = 32'h90;
        b_valid = 1'b1; b_reg = 5'd10; b_data = 32'hA0;
        @(negedge CLK);
        total++; if ({a_ready, b_ready} !== 2'b01) begin bad++; $display("FAIL b2b_rr got=%b exp=01", {a_ready, b_ready}); end
        total++; if ({RegWre, WriteReg} !== {1'b1, 5'd8}) begin bad++; $display("FAIL b2b_w1 got=%b/%0d exp=1/8", RegWre, WriteReg); end
        @(posedge CLK); #1 b_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd10, 32'hA0})
            begin bad++; $display("FAIL b2b_w2 got=%b/%0d/%h exp=1/10/a0", RegWre, WriteReg, WriteData); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_a2 got=%b exp=1", a_ready); end
        @(posedge CLK); #1 a_valid = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg, WriteData} !== {1'b1, 5'd9, 32'h90})
            begin bad++; $display("FAIL b2b_w3 got=%b/%0d/%h exp=1/9/90", RegWre, WriteReg, WriteData); end
    endtask

    task automatic test_saturation();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h111;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h222;
        repeat (300) @(posedge CLK);
        @(negedge CLK);
        total++; if (cont_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", cont_cnt); end
        total++; if ((a_ready ^ b_ready) !== 1'b1) begin bad++; $display("FAIL sat_onehot got=%b exp=one-hot", {a_ready, b_ready}); end
        @(posedge CLK); #1 b_valid = 1'b0;
        @(negedge CLK);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", a_ready); end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        total++; if ({RegWre, WriteReg} !== {1'b1, 5'd1}) begin bad++; $display("FAIL midrst_pend got=%b/%0d exp=1/1", RegWre, WriteReg); end
        total++; if ({a_ready, b_ready} !== 2'b00) begin bad++; $display("FAIL midrst_block got=%b exp=00", {a_ready, b_ready}); end
        @(posedge CLK); #1 begin RST = 1'b1; a_valid = 1'b0; end
        @(negedge CLK);
        total++; if (RegWre !== 1'b0) begin bad++; $display("FAIL midrst_regwre got=%b exp=0", RegWre); end
        total++; if (cont_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", cont_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_collision();
        test_zero();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
